linebuf_seq_ctrl: RTL and testbench

//  Frame-level sequencer for the three-bank Sobel line buffer. Pulls one image line
//  at a time from the SDRAM read FIFO and writes it into the banks in rotation.

---
 rtl/linebuf_seq_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_linebuf_seq_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/linebuf_seq_ctrl.sv
// Frame sequencer for the three-bank Sobel line buffer: FIFO line fetch, bank rotation, read/flush passes.
// Define LBSEQ_ABORT_EN to add the abort_i input that returns a running frame to IDLE.
module linebuf_seq_ctrl #(
  parameter int DATA_WD = 8,
  parameter int ADDR_DW = 10,
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480
) (
  input  logic               sys_clk_i,
  input  logic               rst_ni,
  input  logic               frame_start_i,
`ifdef LBSEQ_ABORT_EN
  input  logic               abort_i,
`endif
  input  logic               ff_rdy_i,
  output logic               ff_rd_o,
  input  logic [DATA_WD-1:0] gray_i,
  output logic [DATA_WD-1:0] wdata_o,
  output logic [ADDR_DW-1:0] waddr_o,
  output logic [2:0]         wram_o,
  output logic [ADDR_DW-1:0] raddr_o,
  output logic               r_en_o,
  output logic [1:0]         rd_ram_o,
  output logic               first_line_o,
  output logic               last_line_o,
  output logic               frame_done_o,
  output logic               busy_o
);

  localparam int                 LCW      = $clog2(IMG_H + 1);
  localparam logic [ADDR_DW-1:0] COL_LAST = ADDR_DW'(IMG_W - 1);
  localparam logic [LCW-1:0]     LINE_END = LCW'(IMG_H);
  localparam logic [LCW-1:0]     LINE_ONE = LCW'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_LINE  = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_DW-1:0] col_q, col_d;
  logic [LCW-1:0]     line_q, line_d;
  logic [1:0]         wbank_q, wbank_d;
  logic [1:0]         wbank_inc;
  logic               col_last;
  logic               abort;

  // Stage 1 carries the write strobe; stage 2 repeats it as the read strobe.
  logic [2:0]         wram1_q, wram1_d;
  logic [ADDR_DW-1:0] addr1_q;
  logic               rd1_q, rd1_d;
  logic [1:0]         rdram1_q, rdram1_d;
  logic               first1_q, first1_d;
  logic               last1_q, last1_d;
  logic               ren2_q;
  logic [ADDR_DW-1:0] raddr2_q;
  logic [1:0]         rdram2_q;
  logic               first2_q;
  logic               last2_q;

`ifdef LBSEQ_ABORT_EN
  assign abort = abort_i && (state_q != S_IDLE);
`else
  assign abort = 1'b0;
`endif

  assign col_last  = (col_q == COL_LAST);
  assign wbank_inc = (wbank_q == 2'd2) ? 2'd0 : wbank_q + 2'd1;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    line_d  = line_q;
    wbank_d = wbank_q;
    case (state_q)
      S_IDLE: begin
        if (frame_start_i) begin
          state_d = S_WAIT;
          col_d   = '0;
          line_d  = '0;
          wbank_d = 2'd0;
        end
      end
      S_WAIT: begin
        if (line_q == LINE_END) begin
          state_d = S_FLUSH;
        end else if (ff_rdy_i) begin
          state_d = S_LINE;
        end
      end
      S_LINE: begin
        if (col_last) begin
          state_d = S_WAIT;
          col_d   = '0;
          line_d  = line_q + LINE_ONE;
          wbank_d = wbank_inc;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      S_FLUSH: begin
        if (col_last) begin
          state_d = S_DONE;
          col_d   = '0;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d = S_IDLE;
      col_d   = '0;
      line_d  = '0;
      wbank_d = 2'd0;
    end
  end

  always_comb begin
    wram1_d  = 3'b000;
    rd1_d    = 1'b0;
    rdram1_d = 2'd0;
    first1_d = 1'b0;
    last1_d  = 1'b0;
    if (state_q == S_LINE) begin
      wram1_d = 3'b001 << wbank_q;
    end
    // Line 0 has no rows above it, so it only fills the buffer.
    if (((state_q == S_LINE) && (line_q != '0)) || (state_q == S_FLUSH)) begin
      rd1_d = 1'b1;
      case (wbank_q)
        2'd0:    rdram1_d = 2'd2;
        2'd1:    rdram1_d = 2'd0;
        default: rdram1_d = 2'd1;
      endcase
      first1_d = (state_q == S_LINE) && (line_q == LINE_ONE);
      last1_d  = (state_q == S_FLUSH);
    end
  end

  always_ff @(posedge sys_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      line_q  <= '0;
      wbank_q <= 2'd0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      line_q  <= line_d;
      wbank_q <= wbank_d;
    end
  end

  always_ff @(posedge sys_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wram1_q  <= 3'b000;
      addr1_q  <= '0;
      rd1_q    <= 1'b0;
      rdram1_q <= 2'd0;
      first1_q <= 1'b0;
      last1_q  <= 1'b0;
      ren2_q   <= 1'b0;
      raddr2_q <= '0;
      rdram2_q <= 2'd0;
      first2_q <= 1'b0;
      last2_q  <= 1'b0;
    end else if (abort) begin
      wram1_q  <= 3'b000;
      addr1_q  <= '0;
      rd1_q    <= 1'b0;
      rdram1_q <= 2'd0;
      first1_q <= 1'b0;
      last1_q  <= 1'b0;
      ren2_q   <= 1'b0;
      raddr2_q <= '0;
      rdram2_q <= 2'd0;
      first2_q <= 1'b0;
      last2_q  <= 1'b0;
    end else begin
      wram1_q  <= wram1_d;
      addr1_q  <= col_q;
      rd1_q    <= rd1_d;
      rdram1_q <= rdram1_d;
      first1_q <= first1_d;
      last1_q  <= last1_d;
      ren2_q   <= rd1_q;
      raddr2_q <= addr1_q;
      rdram2_q <= rdram1_q;
      first2_q <= first1_q;
      last2_q  <= last1_q;
    end
  end

  assign ff_rd_o      = (state_q == S_LINE);
  assign busy_o       = (state_q != S_IDLE);
  assign frame_done_o = (state_q == S_DONE);
  assign wram_o       = wram1_q;
  assign waddr_o      = addr1_q;
  assign wdata_o      = (wram1_q != 3'b000) ? gray_i : '0;
  assign r_en_o       = ren2_q;
  assign raddr_o      = raddr2_q;
  assign rd_ram_o     = rdram2_q;
  assign first_line_o = first2_q;
  assign last_line_o  = last2_q;

endmodule

// File: tb/tb_linebuf_seq_ctrl.sv
// Self-checking bench for linebuf_seq_ctrl (IMG_W=4, IMG_H=3): line-transaction schedule model plus directed literals.
module tb_linebuf_seq_ctrl;
  localparam int W   = 4;
  localparam int H   = 3;
  localparam int AW  = 10;
  localparam int DW  = 8;
  localparam int BIG = 1 << 30;
  localparam int RS  = 64;

  logic          clk = 1'b0;
  logic          rst_ni, frame_start_i, ff_rdy_i, abort_i;
  logic [DW-1:0] gray_i, wdata_o;
  logic          ff_rd_o, r_en_o, first_line_o, last_line_o, frame_done_o, busy_o;
  logic [AW-1:0] waddr_o, raddr_o;
  logic [2:0]    wram_o;
  logic [1:0]    rd_ram_o;

  always #5 clk = ~clk;

  linebuf_seq_ctrl #(.DATA_WD(DW), .ADDR_DW(AW), .IMG_W(W), .IMG_H(H)) dut (
    .sys_clk_i(clk), .rst_ni(rst_ni), .frame_start_i(frame_start_i),
`ifdef LBSEQ_ABORT_EN
    .abort_i(abort_i),
`endif
    .ff_rdy_i(ff_rdy_i), .ff_rd_o(ff_rd_o), .gray_i(gray_i), .wdata_o(wdata_o),
    .waddr_o(waddr_o), .wram_o(wram_o), .raddr_o(raddr_o), .r_en_o(r_en_o),
    .rd_ram_o(rd_ram_o), .first_line_o(first_line_o), .last_line_o(last_line_o),
    .frame_done_o(frame_done_o), .busy_o(busy_o)
  );

  int checks = 0;
  int errors = 0;

  // Model: each accepted line or flush schedules its whole pass onto a cycle timeline.
  int   cyc, bf, bu, wait_from, lines;
  bit   t_ffrd [RS];
  int   t_wram [RS];
  int   t_waddr[RS];
  bit   t_ren  [RS];
  int   t_raddr[RS];
  int   t_rdram[RS];
  bit   t_first[RS];
  bit   t_last [RS];
  bit   t_done [RS];

  // Observations for the literal expectations
  int   n_ffrd, n_ren, n_done, n_frames, t_rd2, t_w, t_r, obs_wd, obs_rd_first, obs_rd_last;
  bit   seen_first;
  int   prev_wram;
  int   bursts[$];

  task automatic clear_slot(input int s);
    t_ffrd[s] = 0; t_wram[s] = 0; t_waddr[s] = 0; t_ren[s] = 0; t_raddr[s] = 0;
    t_rdram[s] = 0; t_first[s] = 0; t_last[s] = 0; t_done[s] = 0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < RS; i++) clear_slot(i);
    bf = BIG; bu = -1; wait_from = BIG; lines = 0;
  endtask

  task automatic sched_pass(input int k, input bit flush, input int n);
    for (int i = 0; i < W; i++) begin
      if (!flush) begin
        t_ffrd[(k + i) % RS]      = 1;
        t_wram[(k + i + 1) % RS]  = 1 << (n % 3);
        t_waddr[(k + i + 1) % RS] = i;
      end
      if (flush || n >= 1) begin
        t_ren  [(k + i + 2) % RS] = 1;
        t_raddr[(k + i + 2) % RS] = i;
        t_rdram[(k + i + 2) % RS] = ((n % 3) + 2) % 3;
        t_first[(k + i + 2) % RS] = !flush && (n == 1);
        t_last [(k + i + 2) % RS] = flush;
      end
    end
    if (flush) t_done[(k + W) % RS] = 1;
  endtask

  task automatic model_edge();
    int  prev;
    bit  pb;
    cyc++;
    prev = cyc - 1;
    pb   = (prev >= bf) && (prev <= bu);
    if (abort_i && pb) begin
      bu = prev; wait_from = BIG;
      for (int d = 0; d < W + 3; d++) clear_slot((cyc + d) % RS);
    end else if (!pb) begin
      if (frame_start_i) begin
        bf = cyc; bu = BIG; lines = 0; wait_from = cyc;
      end
    end else if (prev >= wait_from) begin
      if (lines == H) begin
        sched_pass(cyc, 1'b1, lines);
        bu = cyc + W; wait_from = BIG;
      end else if (ff_rdy_i) begin
        sched_pass(cyc, 1'b0, lines);
        wait_from = cyc + W; lines++;
      end
    end
  endtask

  task automatic cmp(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic obs_reset();
    n_ffrd = 0; n_ren = 0; n_done = 0; t_rd2 = -1; t_w = -1; t_r = -1; obs_wd = -1;
    obs_rd_first = -1; obs_rd_last = -1; seen_first = 0; bursts.delete();
  endtask

  task automatic check();
    int s;
    s = cyc % RS;
    cmp("ff_rd", int'(ff_rd_o), int'(t_ffrd[s]));
    cmp("wram", int'(wram_o), t_wram[s]);
    cmp("r_en", int'(r_en_o), int'(t_ren[s]));
    cmp("first_line", int'(first_line_o), int'(t_first[s]));
    cmp("last_line", int'(last_line_o), int'(t_last[s]));
    cmp("frame_done", int'(frame_done_o), int'(t_done[s]));
    cmp("busy", int'(busy_o), int'((cyc >= bf) && (cyc <= bu)));
    if (t_wram[s] != 0) begin
      cmp("waddr", int'(waddr_o), t_waddr[s]);
      cmp("wdata", int'(wdata_o), int'(gray_i));
    end
    if (t_ren[s]) begin
      cmp("raddr", int'(raddr_o), t_raddr[s]);
      cmp("rd_ram", int'(rd_ram_o), t_rdram[s]);
    end
    clear_slot(s);
    if (ff_rd_o) begin
      n_ffrd++;
      if (n_ffrd == W + 3) t_rd2 = cyc;
    end
    if (r_en_o) n_ren++;
    if (frame_done_o) begin
      n_done++; n_frames++;
      $display("frame %0d done at cycle %0d", n_frames, cyc);
    end
    if (wram_o != 3'b000 && prev_wram == 0) bursts.push_back(int'(wram_o));
    prev_wram = int'(wram_o);
    if (wram_o == 3'b010 && waddr_o == 2 && t_w < 0) begin
      t_w = cyc; obs_wd = int'(wdata_o);
    end
    if (r_en_o && first_line_o) begin
      obs_rd_first = int'(rd_ram_o); seen_first = 1;
      if (raddr_o == 2) t_r = cyc;
    end
    if (r_en_o && last_line_o) obs_rd_last = int'(rd_ram_o);
  endtask

  task automatic step(input bit fs, input bit rdy, input bit ab, input logic [DW-1:0] px);
    frame_start_i = fs; ff_rdy_i = rdy; abort_i = ab; gray_i = px;
    @(posedge clk);
    if (rst_ni) model_edge();
    @(negedge clk);
    check();
  endtask

  task automatic run_to_done(input string nm, input bit rdy, input int fs_every);
    int i;
    i = 0;
    while (n_done == 0 && i < 300) begin
      step((fs_every > 0) && (i % fs_every == 2), rdy, 1'b0, 8'hA5);
      i++;
    end
    if (n_done == 0) cmp({nm, "_timeout"}, 0, 1);
  endtask

  initial begin
    rst_ni = 1'b0; frame_start_i = 0; ff_rdy_i = 0; abort_i = 0; gray_i = '0;
    cyc = 0; n_frames = 0; prev_wram = 0;
    model_clear(); obs_reset();
    repeat (3) step(0, 0, 0, 8'h00);
    rst_ni = 1'b1;
    cmp("reset_busy", int'(busy_o), 0);
    cmp("reset_wram", int'(wram_o), 0);
    repeat (3) step(0, 1, 0, 8'h11);

    // Full frame with FIFO always ready
    obs_reset();
    step(1, 1, 0, 8'hA5);
    run_to_done("t2", 1'b1, 0);
    repeat (3) step(0, 1, 0, 8'hA5);
    cmp("t2_ffrd_count", n_ffrd, 12);
    cmp("t2_ren_count", n_ren, 12);
    cmp("t2_done_count", n_done, 1);
    cmp("t2_burst_count", bursts.size(), 3);
    if (bursts.size() == 3) begin
      cmp("t2_wram0", bursts[0], 1);
      cmp("t2_wram1", bursts[1], 2);
      cmp("t2_wram2", bursts[2], 4);
    end
    cmp("t2_rdram_first", obs_rd_first, 0);
    cmp("t2_rdram_last", obs_rd_last, 2);
    cmp("t3_waddr_lat", t_w - t_rd2, 1);
    cmp("t3_raddr_lat", t_r - t_rd2, 2);
    cmp("t3_wdata", obs_wd, 8'hA5);

    // FIFO starvation after line 0
    obs_reset();
    step(1, 1, 0, 8'h3C);
    step(0, 1, 0, 8'h3C);
    repeat (16) step(0, 0, 0, 8'h3C);
    cmp("t4_ffrd_line0", n_ffrd, W);
    cmp("t4_busy_wait", int'(busy_o), 1);
    bursts.delete();
    run_to_done("t4", 1'b1, 0);
    cmp("t4_resume_wram", (bursts.size() > 0) ? bursts[0] : -1, 2);

    // Mid-frame frame_start pulses, then back-to-back frame
    obs_reset();
    step(1, 1, 0, 8'h5A);
    run_to_done("t5", 1'b1, 5);
    step(1, 1, 0, 8'h5A);
    cmp("t5_done_cycle_pulse_ignored", int'(busy_o), 0);
    step(1, 1, 0, 8'h5A);
    cmp("t5_after_done_accepted", int'(busy_o), 1);
    cmp("t5_single_done", n_done, 1);
    obs_reset();
    run_to_done("t5b", 1'b1, 0);
    cmp("t5b_first_wram", (bursts.size() > 0) ? bursts[0] : -1, 1);

    // Asynchronous reset in the middle of a line
    step(0, 1, 0, 8'h00);
    step(1, 1, 0, 8'h00);
    begin
      int i;
      i = 0;
      while (!ff_rd_o && i < 20) begin
        step(0, 1, 0, 8'h00);
        i++;
      end
      if (!ff_rd_o) cmp("t1_line_timeout", 0, 1);
    end
    #1 rst_ni = 1'b0;
    #1;
    cmp("t1_ff_rd", int'(ff_rd_o), 0);
    cmp("t1_wram", int'(wram_o), 0);
    cmp("t1_r_en", int'(r_en_o), 0);
    cmp("t1_busy", int'(busy_o), 0);
    cmp("t1_flags", int'({first_line_o, last_line_o, frame_done_o}), 0);
    cmp("t1_addr", int'(waddr_o) + int'(raddr_o) + int'(rd_ram_o), 0);
    model_clear();
    repeat (2) step(0, 1, 0, 8'h00);
    rst_ni = 1'b1;
    repeat (3) step(0, 1, 0, 8'h00);
    cmp("t1_release_busy", int'(busy_o), 0);

`ifdef LBSEQ_ABORT_EN
    // Abort during line 1, then a clean restart
    obs_reset();
    step(1, 1, 0, 8'h77);
    begin
      int i;
      i = 0;
      while (bursts.size() < 2 && i < 50) begin
        step(0, 1, 0, 8'h77);
        i++;
      end
    end
    step(0, 1, 1, 8'h77);
    cmp("t6_busy", int'(busy_o), 0);
    cmp("t6_strobes", int'({ff_rd_o, wram_o, r_en_o}), 0);
    repeat (8) step(0, 1, 0, 8'h77);
    cmp("t6_no_done", n_done, 0);
    obs_reset();
    step(1, 1, 0, 8'h77);
    run_to_done("t6", 1'b1, 0);
    cmp("t6_first_wram", (bursts.size() > 0) ? bursts[0] : -1, 1);
    cmp("t6_first_seen", int'(seen_first), 1);
    cmp("t6_first_rdram", obs_rd_first, 0);
`endif

    // Randomized traffic
    for (int i = 0; i < 2500; i++) begin
      bit ab;
      ab = 1'b0;
`ifdef LBSEQ_ABORT_EN
      ab = ($urandom_range(0, 199) == 0);
`endif
      step($urandom_range(0, 15) == 0, $urandom_range(0, 9) < 7, ab, DW'($urandom));
    end
    repeat (20) step(0, 1, 0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
